// File: rtl/riscv_lsu_pkg.sv
// Shared encodings, FSM state type and lane helpers for the data-memory access sequencer.
package riscv_lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_R = 2'd3;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Reserved size is always misaligned so a trapping build rejects it.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [4:0] lane_shift(input logic [1:0] off);
    return {off, 3'b000};
  endfunction

endpackage

// File: rtl/riscv_lane_align.sv
// Combinational byte-lane steering: byte enables, store-data replication and load right-alignment.
module riscv_lane_align
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_aligned
);

  always_comb begin
    be        = BE_W;
    wdata_rep = wdata;
    case (size)
      SIZE_B: begin
        be        = BE_B << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        be        = BE_H << off;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be        = BE_W;
        wdata_rep = wdata;
      end
    endcase
  end

  assign rdata_aligned = rdata_word >> lane_shift(off);

endmodule

// File: rtl/riscv_dm_access.sv
// Load/store sequencer driving a req/ack data-memory handshake with timeout abort.
// Build option MISALIGN_TRAP_EN: misaligned accesses abort with err instead of being force-aligned.
module riscv_dm_access
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack
);

  // state  | meaning
  // S_IDLE | waiting for start; done/err pulse of the previous access shows here
  // S_REQ  | dm_req held, waiting for dm_ack or timeout

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t state, state_nxt;

  logic              we_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:2] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt;

  logic [1:0]  size_eff;
  logic [1:0]  off_eff;
  logic        trap_now;
  logic        tmo_hit;
  logic        accept;
  logic        trap;
  logic        finish;
  logic        abort;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_aligned;

`ifdef MISALIGN_TRAP_EN
  assign trap_now = misaligned(size, addr[1:0]);
`else
  assign trap_now = 1'b0;
`endif

  // Without trapping, reserved size runs as a word and offsets are forced to natural alignment.
  always_comb begin
    size_eff = (size == SIZE_R) ? SIZE_W : size;
    case (size_eff)
      SIZE_H:  off_eff = {addr[1], 1'b0};
      SIZE_W:  off_eff = 2'b00;
      default: off_eff = addr[1:0];
    endcase
  end

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    trap      = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (trap_now) begin
            trap = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dm_ack) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
    end else begin
      done <= finish | abort | trap;
      err  <= abort | trap;
      if (accept) begin
        we_q    <= we;
        size_q  <= size_eff;
        off_q   <= off_eff;
        addr_q  <= addr[ADDR_W-1:2];
        wdata_q <= wdata;
        cnt     <= '0;
      end else if (state == S_REQ && cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
      if (finish && !we_q) rdata <= rdata_aligned;
      else if (abort)      rdata <= '0;
    end
  end

  riscv_lane_align u_align (
    .size          (size_q),
    .off           (off_q),
    .wdata         (wdata_q),
    .rdata_word    (dm_rdata),
    .be            (be),
    .wdata_rep     (wdata_rep),
    .rdata_aligned (rdata_aligned)
  );

  // Memory-side outputs come straight from registers and are zero outside REQ.
  assign busy     = (state != S_IDLE);
  assign dm_req   = (state == S_REQ);
  assign dm_we    = dm_req & we_q;
  assign dm_addr  = dm_req ? {addr_q, 2'b00} : '0;
  assign dm_be    = dm_req ? be : 4'b0000;
  assign dm_wdata = dm_req ? wdata_rep : '0;

endmodule

// File: tb/tb_riscv_dm_access.sv
// Scoreboard bench for riscv_dm_access: expected completions queued at start, checked at done.
module tb_riscv_dm_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          done_cyc;
    int          req_cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_dm_access dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .we       (we),
    .size     (size),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_be    (dm_be),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one access starting at a negedge; returns at the negedge of the done cycle.
  task automatic access(input string tag, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd_word,
                        input int ack_dly, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic e_err, input logic [31:0] e_rdata,
                        input int e_req, input int e_done);
    exp_t e;
    exp_t g;
    int   req_cnt = 0;
    bit   seen = 0;
    bit   fin = 0;
    e = '{err: e_err, rdata: e_rdata, done_cyc: e_done, req_cyc: e_req};
    sb.push_back(e);
    start = 1'b1; we = w; size = sz; addr = a; wdata = wd;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 64 && !fin; c++) begin
      @(negedge clk);
      if (dm_req) begin
        req_cnt++;
        if (!seen) begin
          seen = 1;
          chk({tag, "_addr"},  dm_addr, e_addr);
          chk({tag, "_be"},    {28'd0, dm_be}, {28'd0, e_be});
          chk({tag, "_we"},    {31'd0, dm_we}, {31'd0, w});
          chk({tag, "_wdata"}, dm_wdata, e_wdata);
          chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
        end
      end
      if (err && !done) chk({tag, "_err_stray"}, {31'd0, err}, 32'd0);
      if (done) begin
        fin = 1;
        g = sb.pop_front();
        chk({tag, "_err"},      {31'd0, err}, {31'd0, g.err});
        chk({tag, "_rdata"},    rdata, g.rdata);
        chk({tag, "_done_cyc"}, c, g.done_cyc);
        chk({tag, "_req_cyc"},  req_cnt, g.req_cyc);
        chk({tag, "_idle"},     {31'd0, busy}, 32'd0);
      end
      if (dm_req && (req_cnt - 1) == ack_dly) begin
        dm_ack = 1'b1; dm_rdata = rd_word;
      end else begin
        dm_ack = 1'b0; dm_rdata = 32'h5A5A5A5A;
      end
    end
    dm_ack = 1'b0;
    if (!fin) begin
      chk({tag, "_no_done"}, 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; we = 1'b0; size = 2'd0; addr = '0; wdata = '0;
    dm_rdata = '0; dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'd0, busy},   32'd0);
    chk("rst_done",  {31'd0, done},   32'd0);
    chk("rst_err",   {31'd0, err},    32'd0);
    chk("rst_rdata", rdata,           32'd0);
    chk("rst_req",   {31'd0, dm_req}, 32'd0);
    chk("rst_be",    {28'd0, dm_be},  32'd0);
    chk("rst_addr",  dm_addr,         32'd0);
    rst = 1'b0;
    @(negedge clk);

    access("lw_100", 1'b0, 2'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0,
           32'h100, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF, 1, 2);
    access("lb_103", 1'b0, 2'd0, 32'h103, 32'h0, 32'h80AABBCC, 2,
           32'h100, 4'b1000, 32'h0, 1'b0, 32'h00000080, 3, 4);
    access("sh_202", 1'b1, 2'd1, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 1,
           32'h200, 4'b1100, 32'hABCDABCD, 1'b0, 32'h00000080, 2, 3);
    access("lh_102", 1'b0, 2'd1, 32'h102, 32'h0, 32'h11223344, 0,
           32'h100, 4'b1100, 32'h0, 1'b0, 32'h00001122, 1, 2);
`ifdef MISALIGN_TRAP_EN
    access("lw_101", 1'b0, 2'd2, 32'h101, 32'h0, 32'hCAFEF00D, 0,
           32'h100, 4'b1111, 32'h0, 1'b1, 32'h00001122, 0, 1);
    access("lr_304", 1'b0, 2'd3, 32'h304, 32'h0, 32'h01020304, 1,
           32'h304, 4'b1111, 32'h0, 1'b1, 32'h00001122, 0, 1);
    access("lh_103", 1'b0, 2'd1, 32'h103, 32'h0, 32'hAABBCCDD, 0,
           32'h100, 4'b1100, 32'h0, 1'b1, 32'h00001122, 0, 1);
    access("sb_001", 1'b1, 2'd0, 32'h001, 32'h000000A5, 32'h0, 0,
           32'h000, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h00001122, 1, 2);
`else
    access("lw_101", 1'b0, 2'd2, 32'h101, 32'h0, 32'hCAFEF00D, 0,
           32'h100, 4'b1111, 32'h0, 1'b0, 32'hCAFEF00D, 1, 2);
    access("lr_304", 1'b0, 2'd3, 32'h304, 32'h0, 32'h01020304, 1,
           32'h304, 4'b1111, 32'h0, 1'b0, 32'h01020304, 2, 3);
    access("lh_103", 1'b0, 2'd1, 32'h103, 32'h0, 32'hAABBCCDD, 0,
           32'h100, 4'b1100, 32'h0, 1'b0, 32'h0000AABB, 1, 2);
    access("sb_001", 1'b1, 2'd0, 32'h001, 32'h000000A5, 32'h0, 0,
           32'h000, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0000AABB, 1, 2);
`endif

    // Reset in the middle of a request.
    start = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h600; wdata = '0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_req_before", {31'd0, dm_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req",   {31'd0, dm_req}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy},   32'd0);
    chk("mid_rst_done",  {31'd0, done},   32'd0);
    chk("mid_rst_rdata", rdata,           32'd0);
    @(negedge clk);
    chk("mid_rst_done2", {31'd0, done},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    access("lw_500", 1'b0, 2'd2, 32'h500, 32'h0, 32'h5555AAAA, 3,
           32'h500, 4'b1111, 32'h0, 1'b0, 32'h5555AAAA, 4, 5);
    access("tmo_400", 1'b0, 2'd2, 32'h400, 32'h0, 32'h0, -1,
           32'h400, 4'b1111, 32'h0, 1'b1, 32'h00000000, 16, 17);

    // Acknowledge while idle must have no effect.
    dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    chk("idle_ack_busy",  {31'd0, busy}, 32'd0);
    chk("idle_ack_done",  {31'd0, done}, 32'd0);
    chk("idle_ack_rdata", rdata,         32'd0);
    dm_ack = 1'b0;
    @(negedge clk);

    access("lb_501", 1'b0, 2'd0, 32'h501, 32'h0, 32'h11223344, 0,
           32'h500, 4'b0010, 32'h0, 1'b0, 32'h00112233, 1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
